// File: rtl/network_interface.sv
// Network interface between a mesh router's local port and its core: packetizes
// core events toward the router, depacketizes router traffic toward the core.
module network_interface #(
    parameter int ROUTER_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH        = 4,
    localparam int AW               = ROUTER_ADDR_WIDTH,
    localparam int PW               = 32 - 2*ROUTER_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] router_addr,
    input  logic [AW-1:0] core_tx_dest,
    input  logic [PW-1:0] core_tx_payload,
    input  logic          core_tx_valid,
    output logic          core_tx_ready,
    output logic [31:0]   net_tx_packet,
    output logic          net_tx_valid,
    input  logic          net_tx_ready,
    input  logic [31:0]   net_rx_packet,
    input  logic          net_rx_valid,
    output logic          net_rx_ready,
    output logic [AW-1:0] core_rx_src,
    output logic [PW-1:0] core_rx_payload,
    output logic          core_rx_valid,
    input  logic          core_rx_ready,
    input  logic          stats_clear,
    output logic [15:0]   tx_sent_cnt,
    output logic [15:0]   rx_recv_cnt,
    output logic [15:0]   rx_drop_cnt
);

    localparam int IW   = $clog2(FIFO_DEPTH);
    localparam int PTRW = IW + 1;
    localparam int RXW  = AW + PW;

    logic [31:0]     tx_mem [FIFO_DEPTH];
    logic [RXW-1:0]  rx_mem [FIFO_DEPTH];
    logic [PTRW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic            tx_push, tx_pop, rx_hs, rx_match, rx_push, rx_drop, rx_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign tx_full  = (tx_wr_ptr[PTRW-1] != tx_rd_ptr[PTRW-1]) &&
                      (tx_wr_ptr[IW-1:0] == tx_rd_ptr[IW-1:0]);
    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[PTRW-1] != rx_rd_ptr[PTRW-1]) &&
                      (rx_wr_ptr[IW-1:0] == rx_rd_ptr[IW-1:0]);
    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);

    assign core_tx_ready = !tx_full;
    assign net_tx_valid  = !tx_empty;
    assign net_tx_packet = tx_mem[tx_rd_ptr[IW-1:0]];
    assign net_rx_ready  = !rx_full;
    assign core_rx_valid = !rx_empty;
    assign core_rx_src     = rx_mem[rx_rd_ptr[IW-1:0]][RXW-1:PW];
    assign core_rx_payload = rx_mem[rx_rd_ptr[IW-1:0]][PW-1:0];

    assign tx_push  = core_tx_valid && core_tx_ready;
    assign tx_pop   = net_tx_valid && net_tx_ready;
    assign rx_hs    = net_rx_valid && net_rx_ready;
    assign rx_match = (net_rx_packet[31 -: AW] == router_addr);
    assign rx_push  = rx_hs && rx_match;
    assign rx_drop  = rx_hs && !rx_match;
    assign rx_pop   = core_rx_valid && core_rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTRW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTRW'(1);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTRW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTRW'(1);
        end
    end

    // Storage needs no reset; contents are only observed behind a valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr[IW-1:0]] <= {core_tx_dest, router_addr, core_tx_payload};
        if (rx_push) rx_mem[rx_wr_ptr[IW-1:0]] <= net_rx_packet[RXW-1:0];
    end

    // Saturating debug counters; a clear overrides any same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sent_cnt <= '0;
            rx_recv_cnt <= '0;
            rx_drop_cnt <= '0;
        end else if (stats_clear) begin
            tx_sent_cnt <= '0;
            rx_recv_cnt <= '0;
            rx_drop_cnt <= '0;
        end else begin
            if (tx_pop && tx_sent_cnt != 16'hFFFF)  tx_sent_cnt <= tx_sent_cnt + 16'd1;
            if (rx_push && rx_recv_cnt != 16'hFFFF) rx_recv_cnt <= rx_recv_cnt + 16'd1;
            if (rx_drop && rx_drop_cnt != 16'hFFFF) rx_drop_cnt <= rx_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_network_interface.sv
// Self-checking bench for network_interface: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_network_interface;

    localparam int AW    = 4;
    localparam int PW    = 24;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] router_addr;
    logic [AW-1:0] core_tx_dest;
    logic [PW-1:0] core_tx_payload;
    logic          core_tx_valid;
    logic          core_tx_ready;
    logic [31:0]   net_tx_packet;
    logic          net_tx_valid;
    logic          net_tx_ready;
    logic [31:0]   net_rx_packet;
    logic          net_rx_valid;
    logic          net_rx_ready;
    logic [AW-1:0] core_rx_src;
    logic [PW-1:0] core_rx_payload;
    logic          core_rx_valid;
    logic          core_rx_ready;
    logic          stats_clear;
    logic [15:0]   tx_sent_cnt;
    logic [15:0]   rx_recv_cnt;
    logic [15:0]   rx_drop_cnt;

    int n_compared = 0;
    int n_mismatch = 0;
    bit check_en   = 1'b0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    int m_tx_sent = 0;
    int m_rx_recv = 0;
    int m_rx_drop = 0;

    network_interface #(.ROUTER_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .router_addr(router_addr),
        .core_tx_dest(core_tx_dest), .core_tx_payload(core_tx_payload),
        .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
        .net_tx_packet(net_tx_packet), .net_tx_valid(net_tx_valid), .net_tx_ready(net_tx_ready),
        .net_rx_packet(net_rx_packet), .net_rx_valid(net_rx_valid), .net_rx_ready(net_rx_ready),
        .core_rx_src(core_rx_src), .core_rx_payload(core_rx_payload),
        .core_rx_valid(core_rx_valid), .core_rx_ready(core_rx_ready),
        .stats_clear(stats_clear), .tx_sent_cnt(tx_sent_cnt),
        .rx_recv_cnt(rx_recv_cnt), .rx_drop_cnt(rx_drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: whole packets in queues, handshakes decided from queue occupancy.
    always @(posedge clk or negedge rst_n) begin : ref_model
        bit tx_push, tx_pop, rx_hs, rx_pop;
        if (!rst_n) begin
            tx_q.delete();
            rx_q.delete();
            m_tx_sent = 0;
            m_rx_recv = 0;
            m_rx_drop = 0;
        end else begin
            tx_push = core_tx_valid && (tx_q.size() < DEPTH);
            tx_pop  = net_tx_ready && (tx_q.size() > 0);
            rx_hs   = net_rx_valid && (rx_q.size() < DEPTH);
            rx_pop  = core_rx_ready && (rx_q.size() > 0);
            if (tx_pop) void'(tx_q.pop_front());
            if (tx_push) tx_q.push_back({core_tx_dest, router_addr, core_tx_payload});
            if (rx_pop) void'(rx_q.pop_front());
            if (rx_hs && net_rx_packet[31:28] == router_addr) rx_q.push_back(net_rx_packet);
            if (stats_clear) begin
                m_tx_sent = 0;
                m_rx_recv = 0;
                m_rx_drop = 0;
            end else begin
                if (tx_pop && m_tx_sent < 65535) m_tx_sent++;
                if (rx_hs && net_rx_packet[31:28] == router_addr && m_rx_recv < 65535) m_rx_recv++;
                if (rx_hs && net_rx_packet[31:28] != router_addr && m_rx_drop < 65535) m_rx_drop++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One randomized cycle; senders hold valid and data until the model says accepted.
    task automatic applyStimulus();
        bit tx_acc, rx_acc;
        logic [31:0] pkt;
        tx_acc = core_tx_valid && (tx_q.size() < DEPTH);
        rx_acc = net_rx_valid && (rx_q.size() < DEPTH);
        tick();
        if (!core_tx_valid || tx_acc) begin
            core_tx_valid   = 1'($urandom_range(0, 1));
            core_tx_dest    = 4'($urandom);
            core_tx_payload = 24'($urandom);
        end
        if (!net_rx_valid || rx_acc) begin
            pkt = $urandom;
            if ($urandom_range(0, 1) == 1) pkt[31:28] = router_addr;
            net_rx_valid  = 1'($urandom_range(0, 1));
            net_rx_packet = pkt;
        end
        net_tx_ready  = ($urandom_range(0, 3) != 0);
        core_rx_ready = ($urandom_range(0, 3) != 0);
        stats_clear   = ($urandom_range(0, 63) == 0);
    endtask

    function automatic logic [31:0] bp_pkt(input int k);
        return {4'(k + 1), 4'h5, 24'h000100 + 24'(k)};
    endfunction

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("core_tx_ready", core_tx_ready, tx_q.size() < DEPTH);
                checkOutput("net_tx_valid", net_tx_valid, tx_q.size() > 0);
                if (tx_q.size() > 0) checkOutput("net_tx_packet", net_tx_packet, tx_q[0]);
                checkOutput("net_rx_ready", net_rx_ready, rx_q.size() < DEPTH);
                checkOutput("core_rx_valid", core_rx_valid, rx_q.size() > 0);
                if (rx_q.size() > 0) begin
                    checkOutput("core_rx_src", core_rx_src, rx_q[0][27:24]);
                    checkOutput("core_rx_payload", core_rx_payload, rx_q[0][23:0]);
                end
                checkOutput("tx_sent_cnt", tx_sent_cnt, m_tx_sent);
                checkOutput("rx_recv_cnt", rx_recv_cnt, m_rx_recv);
                checkOutput("rx_drop_cnt", rx_drop_cnt, m_rx_drop);
            end
        end
    end

    initial begin : main_proc
        int k, out, pushed;
        bit acc;
        rst_n = 1'b0;
        router_addr = 4'h5;
        core_tx_dest = '0; core_tx_payload = '0; core_tx_valid = 1'b0;
        net_tx_ready = 1'b0; net_rx_packet = '0; net_rx_valid = 1'b0;
        core_rx_ready = 1'b0; stats_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_en = 1'b1;

        checkOutput("rst_core_tx_ready", core_tx_ready, 1);
        checkOutput("rst_net_rx_ready", net_rx_ready, 1);
        checkOutput("rst_net_tx_valid", net_tx_valid, 0);
        checkOutput("rst_core_rx_valid", core_rx_valid, 0);
        checkOutput("rst_tx_sent_cnt", tx_sent_cnt, 0);
        checkOutput("rst_rx_recv_cnt", rx_recv_cnt, 0);
        checkOutput("rst_rx_drop_cnt", rx_drop_cnt, 0);

        // Basic transmit
        net_tx_ready = 1'b1;
        core_tx_valid = 1'b1; core_tx_dest = 4'hA; core_tx_payload = 24'h000123;
        tick();
        core_tx_valid = 1'b0;
        checkOutput("basic_tx_valid", net_tx_valid, 1);
        checkOutput("basic_tx_packet", net_tx_packet, 32'hA5000123);
        tick();
        checkOutput("basic_tx_sent_cnt", tx_sent_cnt, 1);
        checkOutput("basic_tx_drained", net_tx_valid, 0);

        // Backpressure: fill four, hold a fifth, then drain in order
        net_tx_ready = 1'b0;
        k = 0;
        core_tx_valid = 1'b1; core_tx_dest = 4'(k + 1); core_tx_payload = 24'h000100 + 24'(k);
        repeat (4) begin
            tick();
            k++;
            core_tx_dest = 4'(k + 1); core_tx_payload = 24'h000100 + 24'(k);
        end
        checkOutput("bp_full_ready", core_tx_ready, 0);
        tick();
        checkOutput("bp_still_full", core_tx_ready, 0);
        checkOutput("bp_head", net_tx_packet, 32'h15000100);
        net_tx_ready = 1'b1;
        out = 0;
        pushed = 4;
        repeat (12) begin
            acc = core_tx_valid && (tx_q.size() < DEPTH);
            if (out < pushed) begin
                checkOutput("bp_order", net_tx_packet, bp_pkt(out));
                out++;
            end
            tick();
            if (acc) begin
                pushed++;
                k++;
                if (k < 6) begin
                    core_tx_dest = 4'(k + 1); core_tx_payload = 24'h000100 + 24'(k);
                end else begin
                    core_tx_valid = 1'b0;
                end
            end
        end
        checkOutput("bp_all_out", out, 6);

        // Simultaneous push and pop at occupancy two
        net_tx_ready = 1'b0;
        core_tx_valid = 1'b1; core_tx_dest = 4'hB; core_tx_payload = 24'h000AAA;
        tick();
        core_tx_dest = 4'hC; core_tx_payload = 24'h000BBB;
        tick();
        core_tx_dest = 4'hD; core_tx_payload = 24'h000CCC;
        net_tx_ready = 1'b1;
        tick();
        core_tx_valid = 1'b0; net_tx_ready = 1'b0;
        checkOutput("sim_model_occ", tx_q.size(), 2);
        checkOutput("sim_head", net_tx_packet, 32'hC5000BBB);
        net_tx_ready = 1'b1;
        tick();
        checkOutput("sim_second", net_tx_packet, 32'hD5000CCC);
        tick();
        net_tx_ready = 1'b0;
        checkOutput("sim_empty", net_tx_valid, 0);

        // Clear wins over a same-cycle handshake
        core_tx_valid = 1'b1; core_tx_dest = 4'h1; core_tx_payload = 24'h000001;
        tick();
        core_tx_valid = 1'b0; net_tx_ready = 1'b1; stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0; net_tx_ready = 1'b0;
        checkOutput("clear_wins", tx_sent_cnt, 0);

        // Receive match then mismatch
        core_rx_ready = 1'b0;
        net_rx_valid = 1'b1; net_rx_packet = 32'h53000042;
        tick();
        net_rx_packet = 32'h63000042;
        tick();
        net_rx_valid = 1'b0;
        checkOutput("rx_valid", core_rx_valid, 1);
        checkOutput("rx_src", core_rx_src, 4'h3);
        checkOutput("rx_payload", core_rx_payload, 24'h000042);
        checkOutput("rx_drop_cnt_1", rx_drop_cnt, 1);
        checkOutput("rx_recv_cnt_1", rx_recv_cnt, 1);
        core_rx_ready = 1'b1;
        tick();
        core_rx_ready = 1'b0;
        checkOutput("rx_only_one", core_rx_valid, 0);

        // Receive FIFO full, then one pop frees space
        net_rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            net_rx_packet = 32'h53000000 + 32'(i);
            tick();
        end
        net_rx_packet = 32'h53000004;
        checkOutput("rxfull_ready", net_rx_ready, 0);
        tick();
        core_rx_ready = 1'b1;
        tick();
        core_rx_ready = 1'b0;
        checkOutput("rxfull_freed", net_rx_ready, 1);
        tick();
        net_rx_valid = 1'b0;
        checkOutput("rxfull_again", net_rx_ready, 0);
        core_rx_ready = 1'b1;
        repeat (5) tick();
        core_rx_ready = 1'b0;

        // Randomized traffic against the model
        repeat (2000) applyStimulus();

        // Saturation of the transmit counter
        core_tx_valid = 1'b1; net_tx_ready = 1'b1; net_rx_valid = 1'b0;
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        repeat (65545) tick();
        checkOutput("sat_tx_sent", tx_sent_cnt, 16'hFFFF);
        core_tx_valid = 1'b0;
        repeat (6) tick();

        // Asynchronous reset with both FIFOs occupied
        net_tx_ready = 1'b0; core_rx_ready = 1'b0;
        core_tx_valid = 1'b1; core_tx_dest = 4'h2; core_tx_payload = 24'h000077;
        net_rx_valid = 1'b1; net_rx_packet = 32'h53000077;
        repeat (2) tick();
        core_tx_valid = 1'b0; net_rx_valid = 1'b0;
        checkOutput("pre_rst_tx_valid", net_tx_valid, 1);
        checkOutput("pre_rst_rx_valid", core_rx_valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_tx_valid", net_tx_valid, 0);
        checkOutput("async_rx_valid", core_rx_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_tx_ready", core_tx_ready, 1);
        checkOutput("post_rst_rx_ready", net_rx_ready, 1);
        checkOutput("post_rst_tx_sent", tx_sent_cnt, 0);
        checkOutput("post_rst_rx_recv", rx_recv_cnt, 0);
        checkOutput("post_rst_rx_drop", rx_drop_cnt, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
